// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer sequencer.
//   state_t     : sequencer states, also exported for observation
//   DIV_*       : serial-clock generator divider codes
//   spi_mode_t  : SPI mode encoding {cpol, cpha}
//   spi_mode()  : packs cpol/cpha into a spi_mode_t
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [2:0] DIV_1  = 3'b000;
  localparam logic [2:0] DIV_4  = 3'b001;
  localparam logic [2:0] DIV_8  = 3'b010;
  localparam logic [2:0] DIV_16 = 3'b011;

  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_t;

  function automatic spi_mode_t spi_mode(input logic cpol, input logic cpha);
    return spi_mode_t'({cpol, cpha});
  endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Request/response bundle between a transfer requester and spi_xfer_ctrl.
//
// Handshake: the requester raises start_valid and holds it, together with
// tx_data and cfg_*, until a clk edge where start_valid and start_ready are
// both high; that edge is the accept and the payload is sampled on it.
// start_ready never depends on start_valid. Completion is reported by a
// one-cycle rx_valid pulse with rx_data, which has no back-pressure; rx_data
// holds its value until the next completion.
//
//   master : requester side (drives start_valid, tx_data, cfg_*)
//   slave  : controller side (drives start_ready, rx_data, rx_valid)
interface spi_xfer_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              start_valid;
  logic              start_ready;
  logic [DATA_W-1:0] tx_data;
  logic [2:0]        cfg_div;
  logic              cfg_cpol;
  logic              cfg_cpha;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;

  modport master (
    output start_valid, tx_data, cfg_div, cfg_cpol, cfg_cpha,
    input  start_ready, rx_data, rx_valid
  );

  modport slave (
    input  start_valid, tx_data, cfg_div, cfg_cpol, cfg_cpha,
    output start_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_edge_det.sv
// Serial-clock edge detector.
//   clk, rst   : system clock, async active-high reset
//   sclk       : serial clock from the generator (same clk domain)
//   cpol       : idle level of sclk for the current transfer
//   sclk_edge  : high for one cycle when sclk differs from its registered copy
//   leading    : with sclk_edge, marks a leading (away-from-idle) edge;
//                low marks a trailing edge
module spi_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cpol,
  output logic sclk_edge,
  output logic leading
);

  logic sclk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sclk_q <= 1'b0;
    else     sclk_q <= sclk;
  end

  assign sclk_edge = sclk ^ sclk_q;
  // After a leading edge sclk sits at the non-idle level.
  assign leading   = sclk ^ cpol;

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer. Accepts one word per request, drives cs,
// divider and cpol to an external serial-clock generator, follows that
// generator's sclk to shift mosi / sample miso, and returns the received word.
//   clk, rst   : system clock, async active-high reset
//   req        : request/response bundle (slave side)
//   cs         : active-low chip select
//   divider    : latched divider code to the generator
//   cpol       : latched idle sclk level to the generator
//   sclk       : generator serial clock
//   mosi, miso : serial data out (registered) / in
//   busy       : high whenever not IDLE
//   dbg_state  : current sequencer state
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CS_IDLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  spi_xfer_ctrl_if.slave  req,
  output logic            cs,
  output logic [2:0]      divider,
  output logic            cpol,
  input  logic            sclk,
  output logic            mosi,
  input  logic            miso,
  output logic            busy,
  output state_t          dbg_state
);

  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam int CNT_W  = $clog2(CS_IDLE + 2);

  state_t            state, state_n;
  spi_mode_t         mode_q;
  logic [1:0]        mode_bits;
  logic              cpha;
  logic [DATA_W-1:0] tx_sr, rx_sr, rx_next;
  logic [EDGE_W-1:0] edge_cnt;
  logic [CNT_W-1:0]  phase_cnt;
  logic              sclk_edge, leading;
  logic              accept, shift_fire, last_edge;
  logic              sample_now, drive_now, drive_bit;

  assign mode_bits = mode_q;
  assign cpol      = mode_bits[1];
  assign cpha      = mode_bits[0];

  spi_edge_det u_edge (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cpol      (cpol),
    .sclk_edge (sclk_edge),
    .leading   (leading)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    accept     = 1'b0;
    shift_fire = 1'b0;
    last_edge  = 1'b0;
    case (state)
      IDLE: begin
        if (req.start_valid) begin
          accept  = 1'b1;
          state_n = SETUP;
        end
      end
      // Two cycles with cs high: the generator picks up the new cpol, then
      // the detector's registered copy catches up, so no false edge appears.
      SETUP: begin
        if (phase_cnt == CNT_W'(1)) state_n = SHIFT;
      end
      SHIFT: begin
        if (sclk_edge) begin
          shift_fire = 1'b1;
          if (edge_cnt == EDGE_W'(2 * DATA_W - 1)) begin
            last_edge = 1'b1;
            state_n   = GAP;
          end
        end
      end
      GAP: begin
        if (phase_cnt == CNT_W'(CS_IDLE - 1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign req.start_ready = (state == IDLE) && !rst;
  assign busy            = (state != IDLE);
  assign dbg_state       = state;

  // Cycle counter for the fixed-length SETUP and GAP states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            phase_cnt <= '0;
    else if (state_n != state)                          phase_cnt <= '0;
    else if ((state == SETUP) || (state == GAP))        phase_cnt <= phase_cnt + CNT_W'(1);
    else                                                phase_cnt <= '0;
  end

  // ---------------- datapath ----------------
  // CPHA=0 samples on leading edges and advances mosi on trailing edges (not
  // the last one); CPHA=1 drives on leading edges and samples on trailing.
  assign sample_now = cpha ? !leading : leading;
  assign drive_now  = cpha ? leading  : (!leading && !last_edge);
  // With CPHA=0 the MSB is already on mosi from accept, so the next bit is
  // one below the top of tx_sr; with CPHA=1 the first leading edge drives
  // the MSB itself.
  assign drive_bit  = cpha ? tx_sr[DATA_W-1] : tx_sr[DATA_W-2];
  assign rx_next    = sample_now ? {rx_sr[DATA_W-2:0], miso} : rx_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs           <= 1'b1;
      divider      <= DIV_4;
      mode_q       <= MODE0;
      mosi         <= 1'b0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      edge_cnt     <= '0;
      req.rx_data  <= '0;
      req.rx_valid <= 1'b0;
    end else begin
      req.rx_valid <= 1'b0;
      if (accept) begin
        divider  <= req.cfg_div;
        mode_q   <= spi_mode(req.cfg_cpol, req.cfg_cpha);
        tx_sr    <= req.tx_data;
        mosi     <= req.tx_data[DATA_W-1];
        rx_sr    <= '0;
        edge_cnt <= '0;
      end
      if ((state == SETUP) && (state_n == SHIFT)) cs <= 1'b0;
      if (shift_fire) begin
        edge_cnt <= edge_cnt + EDGE_W'(1);
        rx_sr    <= rx_next;
        if (drive_now) begin
          mosi  <= drive_bit;
          tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
        end
        // cs rises on the cycle after the last sclk transition, before the
        // generator can produce another one.
        if (last_edge) begin
          cs           <= 1'b1;
          req.rx_data  <= rx_next;
          req.rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl, with a serial-clock generator model and a
// selectable miso source (loopback, slave shift model, constant 0).
module tb_spi_xfer_ctrl;
  import spi_pkg::*;

  localparam int CS_IDLE = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_xfer_ctrl_if #(.DATA_W(8)) xif ();
  logic       cs, cpol, sclk, mosi, miso, busy;
  logic [2:0] divider;
  state_t     dbg_state;

  spi_xfer_ctrl #(.DATA_W(8), .CS_IDLE(CS_IDLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (xif.slave),
    .cs        (cs),
    .divider   (divider),
    .cpol      (cpol),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // ---------------- generator model ----------------
  int gen_cnt;
  function automatic int half_period(input logic [2:0] code);
    case (code)
      3'b000:  return 2;
      3'b001:  return 5;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk    <= 1'b0;
      gen_cnt <= 0;
    end else if (cs) begin
      sclk    <= cpol;
      gen_cnt <= 0;
    end else if (gen_cnt == half_period(divider) - 1) begin
      sclk    <= ~sclk;
      gen_cnt <= 0;
    end else begin
      gen_cnt <= gen_cnt + 1;
    end
  end

  // ---------------- miso sources ----------------
  int         miso_sel = 0;     // 0 loopback, 1 slave model, 2 zero
  logic [7:0] slave_word = 8'h00;
  logic       slave_cpol = 1'b0;
  logic       tb_sclk_q = 1'b0;
  int         lead_cnt = 0;
  logic       slave_bit;

  // CPHA=1 slave: presents bit 7-(n-1) after the n-th leading edge.
  always @(posedge clk) begin
    tb_sclk_q <= sclk;
    if (cs) lead_cnt <= 0;
    else if ((sclk != tb_sclk_q) && (sclk != slave_cpol)) lead_cnt <= lead_cnt + 1;
  end

  always_comb begin
    int k;
    k = (lead_cnt == 0) ? 7 : 8 - lead_cnt;
    if (k < 0) k = 0;
    slave_bit = slave_word[k];
  end

  assign miso = (miso_sel == 0) ? mosi : (miso_sel == 1) ? slave_bit : 1'b0;

  // ---------------- monitors ----------------
  int   tog_cnt = 0, rxv_cnt = 0, acc_cnt = 0, viol_cnt = 0;
  int   low_run = 0, last_low = 0;
  logic mon_sclk = 1'b0, mon_cs = 1'b1, mon_cpol = 1'b0;
  logic [2:0] mon_div = 3'b001;

  always @(negedge clk) begin
    mon_sclk <= sclk;
    mon_cs   <= cs;
    mon_div  <= divider;
    mon_cpol <= cpol;
    if (!cs && (sclk != mon_sclk)) tog_cnt <= tog_cnt + 1;
    if (!cs) low_run <= low_run + 1;
    else if (!mon_cs) begin
      last_low <= low_run;
      low_run  <= 0;
    end
    if (xif.rx_valid) rxv_cnt <= rxv_cnt + 1;
    if (xif.start_valid && xif.start_ready) acc_cnt <= acc_cnt + 1;
    if (!cs && !mon_cs && ((divider != mon_div) || (cpol != mon_cpol))) viol_cnt <= viol_cnt + 1;
  end

  // ---------------- driver tasks ----------------
  // Returns at the falling clk edge right after the accepting edge.
  task automatic start_xfer(input logic [7:0] d, input logic [2:0] div, input logic cp,
                            input logic ph, input bit hold, output bit ok);
    @(posedge clk); #1;
    xif.start_valid = 1'b1;
    xif.tx_data     = d;
    xif.cfg_div     = div;
    xif.cfg_cpol    = cp;
    xif.cfg_cpha    = ph;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (xif.start_ready) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk); #1;
      if (!hold) xif.start_valid = 1'b0;
      @(negedge clk);
    end else begin
      xif.start_valid = 1'b0;
    end
  endtask

  // Returns at the falling clk edge where rx_valid is seen.
  task automatic wait_rx(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (xif.rx_valid) ok = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL rst_cs got %b exp 1", cs); end
    checks++; if (divider !== 3'b001) begin errors++; $display("FAIL rst_divider got %b exp 001", divider); end
    checks++; if (cpol !== 1'b0) begin errors++; $display("FAIL rst_cpol got %b exp 0", cpol); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi got %b exp 0", mosi); end
    checks++; if (xif.rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data got %h exp 00", xif.rx_data); end
    checks++; if (xif.rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got %b exp 0", xif.rx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (xif.start_ready !== 1'b0) begin errors++; $display("FAIL rst_start_ready got %b exp 0", xif.start_ready); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state got %0d exp 0", dbg_state); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (xif.start_ready !== 1'b1) begin errors++; $display("FAIL idle_start_ready got %b exp 1", xif.start_ready); end
  endtask

  task automatic test_mode0_loop;
    int t0, r0; bit ok; logic [7:0] e;
    miso_sel = 0; t0 = tog_cnt; r0 = rxv_cnt;
    exp_q.push_back(8'hA5);
    start_xfer(8'hA5, DIV_4, 1'b0, 1'b0, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL m0_accept got 0 exp 1"); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL m0_busy_at_accept got %b exp 1", busy); end
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL m0_cs_a0 got %b exp 1", cs); end
    @(negedge clk);
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL m0_cs_a1 got %b exp 1", cs); end
    @(negedge clk);
    checks++; if (cs !== 1'b0) begin errors++; $display("FAIL m0_cs_a2 got %b exp 0", cs); end
    wait_rx(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL m0_rx_timeout got 0 exp 1"); end
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL m0_cs_with_rx_valid got %b exp 1", cs); end
    e = exp_q.pop_front();
    checks++; if (xif.rx_data !== e) begin errors++; $display("FAIL m0_rx_data got %h exp %h", xif.rx_data, e); end
    repeat (3) @(negedge clk);
    checks++; if (tog_cnt - t0 != 16) begin errors++; $display("FAIL m0_sclk_edges got %0d exp 16", tog_cnt - t0); end
    checks++; if (last_low != 81) begin errors++; $display("FAIL m0_cs_low got %0d exp 81", last_low); end
    checks++; if (rxv_cnt - r0 != 1) begin errors++; $display("FAIL m0_rx_pulses got %0d exp 1", rxv_cnt - r0); end
  endtask

  task automatic test_mode3_slave;
    int t0, bad; bit ok; logic [7:0] e;
    miso_sel = 1; slave_word = 8'hC3; slave_cpol = 1'b1; t0 = tog_cnt;
    exp_q.push_back(8'hC3);
    start_xfer(8'h3C, DIV_1, 1'b1, 1'b1, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL m3_accept got 0 exp 1"); end
    @(negedge clk);
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL m3_sclk_idle got %b exp 1", sclk); end
    wait_rx(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL m3_rx_timeout got 0 exp 1"); end
    e = exp_q.pop_front();
    checks++; if (xif.rx_data !== e) begin errors++; $display("FAIL m3_rx_data got %h exp %h", xif.rx_data, e); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sclk !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL m3_sclk_after_cs got %0d non-idle cycles exp 0", bad); end
    checks++; if (tog_cnt - t0 != 16) begin errors++; $display("FAIL m3_sclk_edges got %0d exp 16", tog_cnt - t0); end
    checks++; if (last_low != 33) begin errors++; $display("FAIL m3_cs_low got %0d exp 33", last_low); end
  endtask

  task automatic test_back_to_back;
    int a0, v0, gap; bit ok, seen, done; logic [7:0] e;
    miso_sel = 0; a0 = acc_cnt; v0 = viol_cnt;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    start_xfer(8'h01, DIV_1, 1'b0, 1'b0, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_accept got 0 exp 1"); end
    @(posedge clk); #1;
    xif.tx_data = 8'h80; xif.cfg_div = DIV_4; xif.cfg_cpol = 1'b1; xif.cfg_cpha = 1'b1;
    wait_rx(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_rx1_timeout got 0 exp 1"); end
    e = exp_q.pop_front();
    checks++; if (xif.rx_data !== e) begin errors++; $display("FAIL b2b_rx1 got %h exp %h", xif.rx_data, e); end
    gap = 1; seen = 1'b0; done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (cs) gap++; else done = 1'b1;
      if (xif.start_ready && !seen) begin
        seen = 1'b1;
        @(posedge clk); #1 xif.start_valid = 1'b0;
      end
    end
    checks++; if (gap < CS_IDLE + 3) begin errors++; $display("FAIL b2b_cs_gap got %0d exp >= %0d", gap, CS_IDLE + 3); end
    wait_rx(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_rx2_timeout got 0 exp 1"); end
    e = exp_q.pop_front();
    checks++; if (xif.rx_data !== e) begin errors++; $display("FAIL b2b_rx2 got %h exp %h", xif.rx_data, e); end
    @(negedge clk);
    checks++; if (acc_cnt - a0 != 2) begin errors++; $display("FAIL b2b_accepts got %0d exp 2", acc_cnt - a0); end
    checks++; if (viol_cnt - v0 != 0) begin errors++; $display("FAIL b2b_cfg_change_cs_low got %0d exp 0", viol_cnt - v0); end
    checks++; if (divider !== 3'b001 || cpol !== 1'b1) begin errors++; $display("FAIL b2b_cfg got div %b cpol %b exp div 001 cpol 1", divider, cpol); end
  endtask

  task automatic test_mode1_zero;
    int bad; bit ok; logic [7:0] e;
    miso_sel = 2;
    exp_q.push_back(8'h00);
    start_xfer(8'hFF, DIV_1, 1'b0, 1'b1, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL m1_accept got 0 exp 1"); end
    checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL m1_mosi_msb got %b exp 1", mosi); end
    bad = 0; ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (xif.rx_valid) ok = 1'b1;
      if (!cs && mosi !== 1'b1) bad++;
    end
    checks++; if (!ok) begin errors++; $display("FAIL m1_rx_timeout got 0 exp 1"); end
    checks++; if (bad != 0) begin errors++; $display("FAIL m1_mosi_hold got %0d low cycles exp 0", bad); end
    e = exp_q.pop_front();
    checks++; if (xif.rx_data !== e) begin errors++; $display("FAIL m1_rx_data got %h exp %h", xif.rx_data, e); end
  endtask

  task automatic test_reset_mid_shift;
    int t0, r0; bit ok; logic [7:0] e;
    miso_sel = 0; t0 = tog_cnt;
    start_xfer(8'h3C, DIV_1, 1'b0, 1'b0, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rs_accept got 0 exp 1"); end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tog_cnt - t0 >= 7) break;
    end
    checks++; if (cs !== 1'b0) begin errors++; $display("FAIL rs_cs_before got %b exp 0", cs); end
    r0 = rxv_cnt;
    #2 rst = 1'b1;
    #1;
    checks++; if (cs !== 1'b1) begin errors++; $display("FAIL rs_cs_async got %b exp 1", cs); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rs_busy got %b exp 0", busy); end
    checks++; if (xif.rx_valid !== 1'b0) begin errors++; $display("FAIL rs_rx_valid got %b exp 0", xif.rx_valid); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rxv_cnt - r0 != 0) begin errors++; $display("FAIL rs_no_rx_pulse got %0d exp 0", rxv_cnt - r0); end
    exp_q.push_back(8'h5A);
    start_xfer(8'h5A, DIV_4, 1'b0, 1'b1, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rs_reaccept got 0 exp 1"); end
    wait_rx(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rs_rx_timeout got 0 exp 1"); end
    e = exp_q.pop_front();
    checks++; if (xif.rx_data !== e) begin errors++; $display("FAIL rs_rx_data got %h exp %h", xif.rx_data, e); end
    repeat (2) @(negedge clk);
    checks++; if (last_low != 81) begin errors++; $display("FAIL rs_cs_low got %0d exp 81", last_low); end
  endtask

  task automatic test_busy_ignore;
    int a0, rdy_hi; bit ok; logic [7:0] e;
    miso_sel = 0; a0 = acc_cnt;
    exp_q.push_back(8'h96);
    start_xfer(8'h96, 3'b110, 1'b1, 1'b0, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bz_accept got 0 exp 1"); end
    checks++; if (divider !== 3'b110 || cpol !== 1'b1) begin errors++; $display("FAIL bz_cfg got div %b cpol %b exp div 110 cpol 1", divider, cpol); end
    @(posedge clk); #1 xif.tx_data = 8'h11;
    rdy_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (xif.start_ready !== 1'b0) rdy_hi++;
    end
    checks++; if (rdy_hi != 0) begin errors++; $display("FAIL bz_ready_while_busy got %0d cycles exp 0", rdy_hi); end
    checks++; if (dbg_state !== SHIFT) begin errors++; $display("FAIL bz_state got %0d exp %0d", dbg_state, SHIFT); end
    @(posedge clk); #1 xif.start_valid = 1'b0;
    wait_rx(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bz_rx_timeout got 0 exp 1"); end
    e = exp_q.pop_front();
    checks++; if (xif.rx_data !== e) begin errors++; $display("FAIL bz_rx_data got %h exp %h", xif.rx_data, e); end
    repeat (4) @(negedge clk);
    checks++; if (acc_cnt - a0 != 1) begin errors++; $display("FAIL bz_accepts got %0d exp 1", acc_cnt - a0); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    xif.start_valid = 1'b0;
    xif.tx_data     = 8'h00;
    xif.cfg_div     = 3'b000;
    xif.cfg_cpol    = 1'b0;
    xif.cfg_cpha    = 1'b0;
    test_reset();
    test_mode0_loop();
    test_mode3_slave();
    test_back_to_back();
    test_mode1_zero();
    test_reset_mid_shift();
    test_busy_ignore();
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
